// File: rtl/alu_exec_ctrl_if.sv
// Bundle of the issue, ALU and writeback handshake signals around the execute sequencer.
// The slave modport is the sequencer's view; master is the view of whatever surrounds it.
interface alu_exec_ctrl_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic [15:0] imm16;
  logic [4:0]  dest_reg;

  logic        alu_start;
  logic [31:0] alu_input_a;
  logic [31:0] alu_input_b;
  logic [4:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_finished;
  logic        alu_err_overflow;
  logic        alu_err_invalid_control;

  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic [4:0]  wb_dest;
  logic        wb_write_en;
  logic [1:0]  exc_code;

  modport slave (
    input  issue_valid, opcode, funct, rs_value, rt_value, imm16, dest_reg,
    output issue_ready,
    output alu_start, alu_input_a, alu_input_b, alu_control,
    input  alu_result, alu_finished, alu_err_overflow, alu_err_invalid_control,
    output wb_valid, wb_result, wb_dest, wb_write_en, exc_code,
    input  wb_ready
  );

  modport master (
    output issue_valid, opcode, funct, rs_value, rt_value, imm16, dest_reg,
    input  issue_ready,
    input  alu_start, alu_input_a, alu_input_b, alu_control,
    output alu_result, alu_finished, alu_err_overflow, alu_err_invalid_control,
    input  wb_valid, wb_result, wb_dest, wb_write_en, exc_code,
    output wb_ready
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: decodes MIPS R/I ALU ops, drives alu_32 through a
// start/finished handshake and hands the result plus exception status to writeback.
module alu_exec_ctrl #(
  parameter logic [4:0]  CTL_AND        = 5'd0,
  parameter logic [4:0]  CTL_OR         = 5'd1,
  parameter logic [4:0]  CTL_ADD        = 5'd2,
  parameter logic [4:0]  CTL_ADDU       = 5'd3,
  parameter logic [4:0]  CTL_SUB        = 5'd6,
  parameter logic [4:0]  CTL_SLT        = 5'd7,
  parameter logic [4:0]  CTL_NOR        = 5'd12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic            clock,
  input logic            reset,
  alu_exec_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic [4:0]         alu_ctl_q, alu_ctl_d;
  logic [4:0]         dest_q, dest_d;
  logic [31:0]        wb_result_q, wb_result_d;
  logic [1:0]         exc_q, exc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               dec_valid;
  logic [4:0]         dec_ctl;
  logic [31:0]        dec_b;
  logic [31:0]        imm_sext;
  logic [31:0]        imm_zext;
  logic [CNT_W-1:0]   cnt_inc;

  assign imm_sext = {{16{bus.imm16[15]}}, bus.imm16};
  assign imm_zext = {16'h0000, bus.imm16};
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    dec_valid = 1'b1;
    dec_ctl   = CTL_AND;
    dec_b     = bus.rt_value;
    case (bus.opcode)
      6'h00: begin
        case (bus.funct)
          6'h20:   dec_ctl = CTL_ADD;
          6'h21:   dec_ctl = CTL_ADDU;
          6'h22:   dec_ctl = CTL_SUB;
          6'h24:   dec_ctl = CTL_AND;
          6'h25:   dec_ctl = CTL_OR;
          6'h27:   dec_ctl = CTL_NOR;
          6'h2A:   dec_ctl = CTL_SLT;
          default: dec_valid = 1'b0;
        endcase
      end
      6'h08: begin dec_ctl = CTL_ADD;  dec_b = imm_sext; end
      6'h09: begin dec_ctl = CTL_ADDU; dec_b = imm_sext; end
      6'h0A: begin dec_ctl = CTL_SLT;  dec_b = imm_sext; end
      6'h0C: begin dec_ctl = CTL_AND;  dec_b = imm_zext; end
      6'h0D: begin dec_ctl = CTL_OR;   dec_b = imm_zext; end
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctl_d   = alu_ctl_q;
    dest_d      = dest_q;
    wb_result_d = wb_result_q;
    exc_d       = exc_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.issue_valid) begin
          alu_a_d     = bus.rs_value;
          alu_b_d     = dec_b;
          alu_ctl_d   = dec_ctl;
          dest_d      = bus.dest_reg;
          wb_result_d = '0;
          // Reserved encodings skip the ALU entirely and report straight to writeback.
          if (dec_valid) begin
            exc_d   = 2'd0;
            state_d = ST_START;
          end else begin
            exc_d   = 2'd2;
            state_d = ST_DONE;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.alu_finished) begin
          wb_result_d = bus.alu_result;
          state_d     = ST_DONE;
          if (bus.alu_err_invalid_control) begin
            exc_d = 2'd2;
          end else if (bus.alu_err_overflow &&
                       (alu_ctl_q == CTL_ADD || alu_ctl_q == CTL_SUB)) begin
            exc_d = 2'd1;
          end else begin
            exc_d = 2'd0;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          wb_result_d = '0;
          exc_d       = 2'd3;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctl_q   <= '0;
      dest_q      <= '0;
      wb_result_q <= '0;
      exc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctl_q   <= alu_ctl_d;
      dest_q      <= dest_d;
      wb_result_q <= wb_result_d;
      exc_q       <= exc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.issue_ready = (state_q == ST_IDLE);
  assign bus.alu_start   = (state_q == ST_START);
  assign bus.alu_input_a = alu_a_q;
  assign bus.alu_input_b = alu_b_q;
  assign bus.alu_control = alu_ctl_q;
  assign bus.wb_valid    = (state_q == ST_DONE);
  assign bus.wb_result   = wb_result_q;
  assign bus.wb_dest     = dest_q;
  assign bus.exc_code    = exc_q;
  assign bus.wb_write_en = (state_q == ST_DONE) && (exc_q == 2'd0) && (dest_q != 5'd0);

endmodule
